alu_issue_stage: RTL and testbench

Execute-stage front end that produces the ALU's operand and opcode inputs.
- Accepts decoded instruction fields and two 64-bit operands over a valid/ready handshake.
- Translates the main-decoder ALU class plus funct3/funct7[5] into the 3-bit ALU opcode.
- Buffers issued operations in a 2-entry skid buffer and presents them to the ALU side with valid/ready.
- Sits between the decode/register-read stage and the ALU.

---
 rtl/alu_issue_pkg.sv | 41 ++++
 rtl/alu_op_decode.sv | 30 +++
 rtl/alu_issue_stage.sv | 93 +++++++++
 tb/tb_alu_issue_stage.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared ALU opcode/class encodings, funct3 constants and the issue-buffer entry.
// The ALU_ISSUE_ILLEGAL_TRAP_EN build option lives in alu_op_decode.
package alu_issue_pkg;

    localparam int ALU_W = 64;

    typedef enum logic [2:0] {
        SUB = 3'b000,
        AND = 3'b001,
        OR  = 3'b011,
        ADD = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        CLS_MEM    = 2'b00,
        CLS_BRANCH = 2'b01,
        CLS_RTYPE  = 2'b10,
        CLS_ITYPE  = 2'b11
    } alu_class_e;

    // Encoding equals buffer occupancy, so the state register doubles as the count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fifo_state_e;

    localparam logic [2:0] F3_ADDSUB = 3'b000;
    localparam logic [2:0] F3_OR     = 3'b110;
    localparam logic [2:0] F3_AND    = 3'b111;

    typedef struct packed {
        alu_op_e          opcode;
        logic             illegal;
        logic [ALU_W-1:0] op1;
        logic [ALU_W-1:0] op2;
    } issue_entry_t;

    localparam issue_entry_t ENTRY_RST = '{opcode: ADD, illegal: 1'b0, op1: '0, op2: '0};

endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: combinational ALU class + funct3/funct7[5] to 3-bit ALU opcode.
// With ALU_ISSUE_ILLEGAL_TRAP_EN defined, unsupported funct3 values raise illegal_o.
module alu_op_decode
    import alu_issue_pkg::*;
(
    input  alu_class_e aluClass_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    output alu_op_e    opcode_o,
    output logic       illegal_o
);

    // Unsupported encodings fall through to ADD, which is also the trap opcode.
    assign opcode_o = aluClass_i == CLS_MEM    ? ADD :
                      aluClass_i == CLS_BRANCH ? SUB :
                      funct3_i == F3_AND       ? AND :
                      funct3_i == F3_OR        ? OR  :
                      (aluClass_i == CLS_RTYPE && funct3_i == F3_ADDSUB && funct7b5_i) ? SUB : ADD;

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    logic supported;

    assign supported = aluClass_i == CLS_MEM || aluClass_i == CLS_BRANCH ||
                       funct3_i == F3_ADDSUB || funct3_i == F3_OR || funct3_i == F3_AND;
    assign illegal_o = !supported;
`else
    assign illegal_o = 1'b0;
`endif

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes ALU ops and buffers them in a 2-entry skid FIFO toward the ALU.
// Optional ALU_ISSUE_ILLEGAL_TRAP_EN flags unsupported decodes (op2 zeroed, illegal_out set).
module alu_issue_stage
    import alu_issue_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 2
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              in_valid_in,
    output logic              in_ready_out,
    input  logic [1:0]        aluClass_in,
    input  logic [2:0]        funct3_in,
    input  logic              funct7b5_in,
    input  logic [DATA_W-1:0] operand1_in,
    input  logic [DATA_W-1:0] operand2_in,
    output logic              out_valid_out,
    input  logic              out_ready_in,
    output logic [2:0]        aluOpcode_out,
    output logic [DATA_W-1:0] operand1_out,
    output logic [DATA_W-1:0] operand2_out,
    output logic              illegal_out
);

    generate
        if (DEPTH != 2 || DATA_W != ALU_W) begin : g_bad_cfg
            $error("alu_issue_stage: DEPTH must be 2 and DATA_W must equal ALU_W");
        end
    endgenerate

    alu_op_e      dec_op;
    logic         dec_ill;
    issue_entry_t new_entry;
    issue_entry_t head;
    issue_entry_t mem_q [2];
    fifo_state_e  state_q;
    fifo_state_e  state_d;
    logic         head_q;
    logic         tail_q;
    logic         in_ready_q;
    logic         out_valid_q;
    logic         accept;
    logic         drain;

    alu_op_decode u_dec (
        .aluClass_i (alu_class_e'(aluClass_in)),
        .funct3_i   (funct3_in),
        .funct7b5_i (funct7b5_in),
        .opcode_o   (dec_op),
        .illegal_o  (dec_ill)
    );

    assign accept = in_valid_in && in_ready_q;
    assign drain  = out_valid_q && out_ready_in;

    always_comb begin
        new_entry = '{opcode: dec_op, illegal: dec_ill, op1: operand1_in,
                      op2: dec_ill ? '0 : operand2_in};
        state_d   = fifo_state_e'(state_q + 2'(accept) - 2'(drain));
    end

    // Handshake outputs are registered from the next state, so in_ready has no path from out_ready.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= EMPTY;
            head_q      <= 1'b0;
            tail_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            mem_q[0]    <= ENTRY_RST;
            mem_q[1]    <= ENTRY_RST;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= state_d != FULL;
            out_valid_q <= state_d != EMPTY;
            if (accept) begin
                mem_q[tail_q] <= new_entry;
                tail_q        <= !tail_q;
            end
            if (drain) head_q <= !head_q;
        end
    end

    assign head          = mem_q[head_q];
    assign in_ready_out  = in_ready_q;
    assign out_valid_out = out_valid_q;
    assign aluOpcode_out = head.opcode;
    assign operand1_out  = head.op1;
    assign operand2_out  = head.op2;
    assign illegal_out   = head.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: randomized scoreboard bench for alu_issue_stage with a behavioural model.
// Honours ALU_ISSUE_ILLEGAL_TRAP_EN the same way as the design build.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  cls = '0;
    logic [2:0]  f3 = '0;
    logic        f7b5 = 1'b0;
    logic [63:0] a_in = '0;
    logic [63:0] b_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [2:0]  opc;
    logic [63:0] a_out;
    logic [63:0] b_out;
    logic        ill;
    logic        rnd_on = 1'b0;

    typedef struct packed {
        logic [2:0]  op;
        logic        ill;
        logic [63:0] a;
        logic [63:0] b;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int n_out = 0;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .in_valid_in   (in_valid),
        .in_ready_out  (in_ready),
        .aluClass_in   (cls),
        .funct3_in     (f3),
        .funct7b5_in   (f7b5),
        .operand1_in   (a_in),
        .operand2_in   (b_in),
        .out_valid_out (out_valid),
        .out_ready_in  (out_ready),
        .aluOpcode_out (opc),
        .operand1_out  (a_out),
        .operand2_out  (b_out),
        .illegal_out   (ill)
    );

    task automatic check(input string name, input logic [131:0] act, input logic [131:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: MEM adds, BRANCH subtracts, R/I types select by funct3; anything else is unsupported.
    function automatic exp_t model(input logic [1:0] c, input logic [2:0] f, input logic f7,
                                   input logic [63:0] a, input logic [63:0] b);
        exp_t e;
        logic bad;
        e   = '{op: 3'b111, ill: 1'b0, a: a, b: b};
        bad = 1'b0;
        if (c == 2'd1) e.op = 3'b000;
        else if (c >= 2'd2) begin
            if (f == 3'd0) e.op = (c == 2'd2 && f7) ? 3'b000 : 3'b111;
            else if (f == 3'd7) e.op = 3'b001;
            else if (f == 3'd6) e.op = 3'b011;
            else bad = 1'b1;
        end
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
        if (bad) begin
            e.ill = 1'b1;
            e.b   = '0;
        end
`else
        if (bad) e.ill = 1'b0;
`endif
        return e;
    endfunction

    function automatic logic [63:0] alu(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        case (op)
            3'b000:  return a - b;
            3'b001:  return a & b;
            3'b011:  return a | b;
            3'b111:  return a + b;
            default: return 64'hx;
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got op=%0h a=%0h b=%0h expected no output", opc, a_out, b_out);
            end else begin
                check("head", {opc, ill, a_out, b_out}, q[0]);
                if (out_ready) begin
                    void'(q.pop_front());
                    n_out++;
                end
            end
        end
    end

    always @(posedge clk) if (rnd_on) begin
        #1;
        out_ready = 1'($urandom_range(0, 1));
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic [1:0] c, input logic [2:0] f, input logic f7,
                         input logic [63:0] a, input logic [63:0] b);
        cls = c; f3 = f; f7b5 = f7; a_in = a; b_in = b; in_valid = 1'b1;
    endtask

    // Holds the op until accepted; the expected result enters the scoreboard on the accepting cycle.
    task automatic send(input logic [1:0] c, input logic [2:0] f, input logic f7,
                        input logic [63:0] a, input logic [63:0] b);
        drive(c, f, f7, a, b);
        for (int w = 0; w < 100; w++) begin
            @(negedge clk);
            if (in_ready) begin
                q.push_back(model(c, f, f7, a, b));
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        n_cmp++;
        n_bad++;
        $display("FAIL send_timeout: got in_ready=0 for 100 cycles expected accept");
        in_valid = 1'b0;
    endtask

    task automatic send_rand();
        send(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             {$urandom, $urandom}, {$urandom, $urandom});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        exp_t e;
        idle(2);
        check("rst_valid", out_valid, 1'b0);
        check("rst_ready", in_ready, 1'b1);
        check("rst_payload", {opc, ill, a_out, b_out}, {3'b111, 1'b0, 64'd0, 64'd0});
        rst_n = 1'b1;
        idle(1);

        out_ready = 1'b1;
        send(2'd2, 3'd0, 1'b1, 64'd10, 64'd3);
        check("t1_valid", out_valid, 1'b1);
        check("t1_payload", {opc, a_out, b_out}, {3'b000, 64'd10, 64'd3});
        check("t1_alu_result", alu(opc, a_out, b_out), 64'd7);
        idle(2);

        out_ready = 1'b0;
        send(2'd0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 64'd1, 64'd2);
        send(2'd2, 3'd6, 1'b0, 64'hF0, 64'h0F);
        drive(2'd3, 3'd7, 1'b0, 64'd5, 64'd3);
        @(negedge clk);
        check("t2_full_ready", in_ready, 1'b0);
        check("t2_full_valid", out_valid, 1'b1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(2'd3, 3'd7, 1'b0, 64'd5, 64'd3);
        idle(4);
        check("t2_drained", 132'(q.size()), 132'd0);

        base = n_out;
        for (int i = 0; i < 16; i++) begin
            drive(2'd3, (i % 2) ? 3'd6 : 3'd7, 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom});
            @(negedge clk);
            check("t3_ready", in_ready, 1'b1);
            if (i > 0) check("t3_no_bubble", out_valid, 1'b1);
            if (in_ready) q.push_back(model(cls, f3, f7b5, a_in, b_in));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        idle(2);
        check("t3_count", 132'(n_out - base), 132'd16);

        out_ready = 1'b0;
        send_rand();
        send_rand();
        drive(2'd2, 3'd7, 1'b0, {$urandom, $urandom}, {$urandom, $urandom});
        out_ready = 1'b1;
        base = n_out;
        @(negedge clk);
        check("t4_full_ready", in_ready, 1'b0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("t4_ready_rise", in_ready, 1'b1);
        check("t4_one_drain", 132'(n_out - base), 132'd1);
        if (in_ready) q.push_back(model(cls, f3, f7b5, a_in, b_in));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        idle(4);
        check("t4_drained", 132'(q.size()), 132'd0);

        out_ready = 1'b0;
        send_rand();
        send_rand();
        #2;
        rst_n = 1'b0;
        q.delete();
        #1;
        check("t5_async_valid", out_valid, 1'b0);
        idle(2);
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_ready", in_ready, 1'b1);
        check("t5_payload", {out_valid, opc, ill, a_out, b_out}, {1'b0, 3'b111, 1'b0, 64'd0, 64'd0});
        out_ready = 1'b1;
        idle(3);
        @(negedge clk);
        check("t5_no_stale", out_valid, 1'b0);
        @(posedge clk);
        #1;

        send(2'd3, 3'd2, 1'b1, 64'd7, 64'd9);
        e = model(2'd3, 3'd2, 1'b1, 64'd7, 64'd9);
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
        check("t6_illegal", {ill, opc, b_out}, {1'b1, 3'b111, 64'd0});
`else
        check("t6_illegal", {ill, opc, b_out}, {1'b0, 3'b111, 64'd9});
`endif
        check("t6_model", {opc, ill, a_out, b_out}, e);
        idle(2);

        rnd_on = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send_rand();
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        rnd_on = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int w = 0; w < 20 && q.size() != 0; w++) idle(1);
        check("final_drain", 132'(q.size()), 132'd0);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
